// File: rtl/serial_led_strip_driver.sv
// serial_led_strip_driver
//   FIFO-buffered NRZ LED strip driver. Queued words are streamed back-to-back
//   as one frame, MSB first, either 24-bit or full-width per word, and the
//   frame is closed by a low latch period of RESET_US microseconds.
// Ports:
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   enable_i              permits a new word to start transmitting
//   wr_en_i               push request (accepted when wr_ready_o=1)
//   word24_i, led_data_i  word format flag and data pushed with wr_en_i
//   wr_ready_o            FIFO not full
//   fifo_count_o          occupied FIFO entries
//   led_data_o            registered serial LED line
//   busy_o                transmitter not idle
//   frame_done_o          one-cycle pulse on the last latch cycle
//   overflow_o            sticky, set by a push attempt while full
module serial_led_strip_driver #(
  parameter int unsigned CLOCK_FREQ    = 12000000,
  parameter int unsigned LED_DATA_WORD = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned RESET_US      = 80,
  localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     wr_en_i,
  input  logic                     word24_i,
  input  logic [LED_DATA_WORD-1:0] led_data_i,
  output logic                     wr_ready_o,
  output logic [CW-1:0]            fifo_count_o,
  output logic                     led_data_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     overflow_o
);

  localparam int unsigned BIT_TICKS   = CLOCK_FREQ / 800000;
  localparam int unsigned T0H         = BIT_TICKS * 3 / 10;
  localparam int unsigned T1H         = BIT_TICKS * 6 / 10;
  localparam int unsigned RESET_TICKS = (CLOCK_FREQ / 1000000) * RESET_US;
  localparam int unsigned TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned LW = $clog2(RESET_TICKS + 1);
  localparam int unsigned BW = $clog2(LED_DATA_WORD + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TICK_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] T0H_C      = TW'(T0H);
  localparam logic [TW-1:0] T1H_C      = TW'(T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_TICKS - 1);
  localparam logic [BW-1:0] BITS_24    = BW'(24);
  localparam logic [BW-1:0] BITS_FULL  = BW'(LED_DATA_WORD);
  localparam logic [BW-1:0] BITS_ONE   = BW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  // FIFO
  logic [LED_DATA_WORD:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     push, pop;
  logic [LED_DATA_WORD:0]   head;
  logic                     have_word;

  assign wr_ready_o   = (count != COUNT_FULL);
  assign fifo_count_o = count;
  assign push         = wr_en_i && wr_ready_o;
  assign head         = mem[rd_ptr];
  assign have_word    = (count != '0);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {word24_i, led_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en_i && !wr_ready_o) overflow_o <= 1'b1;
    end
  end

  // Transmitter
  state_t                   state, state_n;
  logic [LED_DATA_WORD-1:0] shreg, shreg_n;
  logic                     w24, w24_n;
  logic [BW-1:0]            bits_left, bits_left_n;
  logic [TW-1:0]            tick, tick_n;
  logic [LW-1:0]            lcnt, lcnt_n;
  logic                     cur_bit, led_n;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      shreg      <= '0;
      w24        <= 1'b0;
      bits_left  <= '0;
      tick       <= '0;
      lcnt       <= '0;
      led_data_o <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      w24        <= w24_n;
      bits_left  <= bits_left_n;
      tick       <= tick_n;
      lcnt       <= lcnt_n;
      led_data_o <= led_n;
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    w24_n        = w24;
    bits_left_n  = bits_left;
    tick_n       = tick;
    lcnt_n       = lcnt;
    pop          = 1'b0;
    frame_done_o = 1'b0;
    cur_bit      = w24 ? shreg[23] : shreg[LED_DATA_WORD-1];

    case (state)
      IDLE: begin
        if (enable_i && have_word) begin
          pop         = 1'b1;
          shreg_n     = head[LED_DATA_WORD-1:0];
          w24_n       = head[LED_DATA_WORD];
          bits_left_n = head[LED_DATA_WORD] ? BITS_24 : BITS_FULL;
          tick_n      = '0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (tick == TICK_LAST) begin
          tick_n = '0;
          if (bits_left > BITS_ONE) begin
            shreg_n     = {shreg[LED_DATA_WORD-2:0], 1'b0};
            bits_left_n = bits_left - BITS_ONE;
          end else if (enable_i && have_word) begin
            // Reload on the last tick of the word keeps the frame seamless.
            pop         = 1'b1;
            shreg_n     = head[LED_DATA_WORD-1:0];
            w24_n       = head[LED_DATA_WORD];
            bits_left_n = head[LED_DATA_WORD] ? BITS_24 : BITS_FULL;
          end else begin
            lcnt_n  = '0;
            state_n = LATCH;
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      LATCH: begin
        if (lcnt == LATCH_LAST) begin
          frame_done_o = 1'b1;
          state_n      = IDLE;
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    led_n = (state == SEND) && (tick < (cur_bit ? T1H_C : T0H_C));
  end

endmodule

// File: doc/serial_led_strip_driver.md
Name: serial_led_strip_driver

Overview:
FIFO-buffered serial LED strip driver that streams any number of LED words back-to-back as one NRZ frame, then ends the frame with a latch/reset low period. It supports 24-bit (RGB) or full-width (e.g. 32-bit RGBW) words, selectable per word. Bit timing is derived from the clock-frequency parameter. It sits between the bus-side LED register block and the LED data pin.

Parameters:
CLOCK_FREQ, 12000000, system clock in Hz.
LED_DATA_WORD, 32, maximum word width in bits; must be >= 24.
FIFO_DEPTH, 8, number of word entries; must be a power of two and >= 2.
RESET_US, 80, latch low time in microseconds.
Derived values (integer division):
- BIT_TICKS = CLOCK_FREQ/800000
- T0H = BIT_TICKS*3/10
- T1H = BIT_TICKS*6/10
- RESET_TICKS = (CLOCK_FREQ/1000000)*RESET_US
- CW = $clog2(FIFO_DEPTH+1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
enable_i  in  1  permits new words to start transmitting
wr_en_i  in  1  push request, valid when wr_ready_o=1
word24_i  in  1  written with the word: 1 = send bits [23:0], 0 = send [LED_DATA_WORD-1:0]
led_data_i  in  LED_DATA_WORD  word to push
wr_ready_o  out  1  FIFO not full
fifo_count_o  out  CW  number of occupied entries
led_data_o  out  1  serial LED line, registered
busy_o  out  1  state != IDLE
frame_done_o  out  1  single-cycle pulse at the end of the latch period
overflow_o  out  1  sticky; set by a push attempt while full

Behaviour:
Reset (asynchronous, takes effect immediately):
- state=IDLE; FIFO emptied, so fifo_count_o=0 and wr_ready_o=1.
- led_data_o=0, busy_o=0, frame_done_o=0, overflow_o=0.
- All counters cleared. Reset mid-bit truncates the pulse immediately; there is no recovery frame.

FIFO:
- Each entry stores {word24, data}.
- A push occurs when wr_en_i && wr_ready_o. It is visible in fifo_count_o on the next cycle.
- wr_en_i while full: the word is dropped and overflow_o is set. This holds even if a pop happens in the same cycle; there is no full bypass.
- There is no empty bypass. A word pushed in cycle N can be popped in cycle N+1 at the earliest.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

State machine:
- IDLE:
  - If enable_i && count>0: pop the head into the shift register; bits_left = 24 or LED_DATA_WORD; tick=0; go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - The transmitted bit is shift-register bit 23 (24-bit word) or bit LED_DATA_WORD-1 (full word); MSB first.
  - tick counts 0..BIT_TICKS-1.
  - When tick=BIT_TICKS-1 and bits_left>1: shift left by 1, decrement bits_left, tick=0.
  - When tick=BIT_TICKS-1 and bits_left=1 (end of word):
    - If enable_i && count>0: pop the next word in the same cycle and stay in SEND. There is no gap between words.
    - Otherwise go to LATCH with its counter at 0.
  - Dropping enable_i mid-word never truncates the word. It only blocks the next pop.
- LATCH:
  - The line is held low for RESET_TICKS cycles.
  - On the last latch cycle, frame_done_o=1 for one cycle and the state returns to IDLE.
  - Words pushed during LATCH wait and start a new frame from IDLE.

Output timing:
- led_data_o is registered from (state==SEND && tick < (bit ? T1H : T0H)).
- The first high edge appears 1 cycle after the pop.
- Every bit period is exactly BIT_TICKS cycles; the frame's word-to-word spacing is seamless.
- After the last bit, the line is low for at least RESET_TICKS cycles before any new frame starts.

Widths:
- tick is $clog2(BIT_TICKS) bits.
- The latch counter is $clog2(RESET_TICKS+1) bits.
- bits_left is $clog2(LED_DATA_WORD+1) bits.
- All compares are unsigned.

Test Plan:
1. Single word, 24-bit mode. Setup: CLOCK_FREQ=8000000, RESET_US=2, so BIT_TICKS=10, T0H=3, T1H=6, RESET_TICKS=16. Push 0xA5A5A5 with word24_i=1 and enable_i=1.
   -> 24 periods of 10 cycles with high widths 6,3,6,3,...
   -> Then 16 low cycles, one frame_done_o pulse, busy_o=0.
2. Three 32-bit words pushed back-to-back: 0xFFFFFFFF, 0x00000000, 0x80000001.
   -> 96 contiguous bit periods with no extra cycles between words.
   -> Exactly one latch period and one frame_done_o pulse.
3. enable_i=0, push 9 words with FIFO_DEPTH=8.
   -> wr_ready_o=0 after 8 words; fifo_count_o=8; 9th word dropped; overflow_o=1.
   -> Then raise enable_i: exactly 8 words are sent.
4. Drop enable_i at bit 5 of word 1 while word 2 is queued.
   -> Word 1 completes all bits, then the latch period.
   -> Word 2 stays queued (fifo_count_o=1) until enable_i rises again.
5. Push a word during LATCH.
   -> Its first high edge appears no earlier than 1 cycle after frame_done_o. The low gap is >= 16 cycles.
6. Assert rst_i asynchronously mid-bit while high, with 3 words queued.
   -> led_data_o=0 immediately; fifo_count_o=0, busy_o=0, overflow_o=0.
   -> No output activity after release until a new push.
